// File: rtl/decoder_onehot_seq.sv
// Registered binary-to-one-hot decoder with valid/ready intake and LEVEL/PULSE output modes.
// Optional DECODER_ERR_EN adds a sticky out-of-range flag (err) with synchronous clear (err_clr).
//
//  state | meaning
//  IDLE  | ready for a command; out holds the last LEVEL result (or zero)
//  HOLD  | PULSE strobe active; counter counts down remaining cycles
module decoder_onehot_seq #(
  parameter int IN_W        = 2,
  parameter int NUM_OUT     = 4,
  parameter int HOLD_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_sel,
  output logic [NUM_OUT-1:0] out,
  output logic               out_valid,
  output logic               busy
`ifdef DECODER_ERR_EN
  ,
  output logic               err,
  input  logic               err_clr
`endif
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IN_W:0]      NUM_OUT_V = NUM_OUT[IN_W:0];
  localparam logic [NUM_OUT-1:0] ONE       = NUM_OUT'(1);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               in_range;
  logic [NUM_OUT-1:0] dec;

  // rst_n gates ready so nothing looks acceptable while reset is held.
  assign in_ready = rst_n & en & (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign in_range = ({1'b0, in_sel} < NUM_OUT_V);
  assign dec      = in_range ? (ONE << in_sel) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (!en) begin
      state     <= IDLE;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            out       <= dec;
            out_valid <= 1'b1;
            if (mode) begin
              state <= HOLD;
              cnt   <= HOLD_LOAD;
              busy  <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state <= IDLE;
            out   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          out   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DECODER_ERR_EN
  // Independent of en so a disable does not lose the error record; set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept && !in_range) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Directed bench for decoder_onehot_seq (IN_W=3, NUM_OUT=5, HOLD_CYCLES=3) with an out_valid scoreboard.
module tb_decoder_onehot_seq;

  logic       clk = 1'b0;
  logic       rst_n, en, mode, in_valid, in_ready;
  logic [2:0] in_sel;
  logic [4:0] out;
  logic       out_valid, busy;
  logic       err, err_clr;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  decoder_onehot_seq #(.IN_W(3), .NUM_OUT(5), .HOLD_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .out(out), .out_valid(out_valid), .busy(busy)
`ifdef DECODER_ERR_EN
    , .err(err), .err_clr(err_clr)
`endif
  );

`ifndef DECODER_ERR_EN
  assign err = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] model(input int s);
    logic [4:0] one = 5'b00001;
    return (s < 5) ? (one << s) : 5'b00000;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cmd(input int s, input logic m);
    in_valid = 1'b1;
    in_sel   = 3'(s);
    mode     = m;
    exp_q.push_back(model(s));
  endtask

  // Scoreboard: every out_valid strobe must match the oldest accepted command.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed out_valid with out %0h, expected no strobe", out);
      end
      if (exp_q.size() > 0) check("sb_out", 32'(out), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; in_valid = 1'b0; in_sel = '0; err_clr = 1'b0;
    repeat (2) tick();
    check("rst_out", 32'(out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_ovalid", 32'(out_valid), 32'd0);
    rst_n = 1'b1; en = 1'b1;
    #1 check("rel_ready", 32'(in_ready), 32'd1);

    // LEVEL sweep, back-to-back
    for (int s = 0; s < 5; s++) begin
      cmd(s, 1'b0);
      tick();
      check("lvl_ovalid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("lvl_hold", 32'(out), 32'(5'b10000));
    check("lvl_ovalid_drop", 32'(out_valid), 32'd0);

    // PULSE sel=2, in_valid held during HOLD must be ignored
    cmd(2, 1'b1);
    tick();
    in_valid = 1'b1; in_sel = 3'd3;
    for (int c = 0; c < 3; c++) begin
      check("pls_out", 32'(out), 32'(5'b00100));
      check("pls_busy", 32'(busy), 32'd1);
      check("pls_ready", 32'(in_ready), 32'd0);
      tick();
      in_valid = 1'b0;
    end
    check("pls_clr_out", 32'(out), 32'd0);
    check("pls_clr_busy", 32'(busy), 32'd0);
    check("pls_clr_ready", 32'(in_ready), 32'd1);
    check("pls_clr_ovalid", 32'(out_valid), 32'd0);

    // mode flip during HOLD does not shorten/extend the strobe
    cmd(0, 1'b1);
    tick();
    in_valid = 1'b0; mode = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("mc_out", 32'(out), 32'(5'b00001));
      check("mc_busy", 32'(busy), 32'd1);
      tick();
    end
    check("mc_end_out", 32'(out), 32'd0);
    check("mc_end_busy", 32'(busy), 32'd0);
    cmd(3, 1'b0);
    tick();
    in_valid = 1'b0;
    check("mc_lvl_busy", 32'(busy), 32'd0);
    tick();
    check("mc_lvl_out", 32'(out), 32'(5'b01000));
    check("mc_lvl_ready", 32'(in_ready), 32'd1);

    // abort on 2nd HOLD cycle
    cmd(4, 1'b1);
    tick();
    in_valid = 1'b0;
    check("ab_out1", 32'(out), 32'(5'b10000));
    tick();
    check("ab_busy2", 32'(busy), 32'd1);
    en = 1'b0;
    #1 check("ab_ready_off", 32'(in_ready), 32'd0);
    tick();
    check("ab_out", 32'(out), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_ovalid", 32'(out_valid), 32'd0);
    en = 1'b1;
    #1 check("ab_ready_on", 32'(in_ready), 32'd1);
    cmd(1, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    check("ab_reacc", 32'(out), 32'(5'b00010));

    // out-of-range LEVEL
    cmd(6, 1'b0);
    tick();
    in_valid = 1'b0;
    check("rng_ovalid", 32'(out_valid), 32'd1);
    check("rng_out", 32'(out), 32'd0);
`ifdef DECODER_ERR_EN
    check("err_set", 32'(err), 32'd1);
    tick();
    check("err_sticky", 32'(err), 32'd1);
    en = 1'b0;
    tick();
    check("err_en0", 32'(err), 32'd1);
    en = 1'b1; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr", 32'(err), 32'd0);
    cmd(7, 1'b0);
    err_clr = 1'b1;
    tick();
    in_valid = 1'b0; err_clr = 1'b0;
    check("err_setwins", 32'(err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr2", 32'(err), 32'd0);
`endif
    tick();
    check("rng_ovalid_drop", 32'(out_valid), 32'd0);

    // out-of-range PULSE keeps uniform HOLD timing
    cmd(5, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("rngp_busy", 32'(busy), 32'd1);
      check("rngp_out", 32'(out), 32'd0);
      tick();
    end
    check("rngp_end", 32'(busy), 32'd0);
    check("rngp_ready", 32'(in_ready), 32'd1);

    // async reset mid-HOLD
    cmd(2, 1'b1);
    tick();
    in_valid = 1'b0;
    check("mr_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_out", 32'(out), 32'd0);
    check("mr_busy0", 32'(busy), 32'd0);
    check("mr_ready", 32'(in_ready), 32'd0);
    check("mr_err", 32'(err), 32'd0);
    tick();
    rst_n = 1'b1;
    #1 check("mr_rel_ready", 32'(in_ready), 32'd1);
    tick();
    check("mr_post_out", 32'(out), 32'd0);
    check("mr_post_busy", 32'(busy), 32'd0);
    check("mr_post_ovalid", 32'(out_valid), 32'd0);

    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
